// File: rtl/banked_mem_arbiter.sv
// banked_mem_arbiter: NUM_PORTS requesters share NUM_BANKS word-interleaved
// single-port banks. Each port runs IDLE/WAIT/DONE. Each bank grants at most
// one port per cycle, using fixed priority or a per-bank round-robin. A
// saturating counter records the cycles in which any request lost arbitration.
module banked_mem_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter int NUM_BANKS   = 4,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 8192,
   parameter int ARB_MODE    = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          mem_req,
   input  logic [NUM_PORTS-1:0]          mem_we,
   input  logic [NUM_PORTS*DATA_W/8-1:0] mem_be,
   input  logic [NUM_PORTS*ADDR_W-1:0]   mem_addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   mem_wdata,
   output logic [NUM_PORTS*DATA_W-1:0]   mem_rdata,
   output logic [NUM_PORTS-1:0]          mem_ready,
   output logic [15:0]                   conflict_cnt
);

   localparam int BE_W   = DATA_W / 8;
   localparam int ROWS   = DEPTH_WORDS / NUM_BANKS;
   localparam int LOG_NB = $clog2(NUM_BANKS);
   localparam int BANK_W = (NUM_BANKS > 1) ? LOG_NB : 1;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int WORD_W = ADDR_W - 2;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t              r_state     [NUM_PORTS];
   state_t              w_state_nxt [NUM_PORTS];
   logic [WORD_W-1:0]   w_word      [NUM_PORTS];
   logic [BANK_W-1:0]   w_bank      [NUM_PORTS];
   logic [ROW_W-1:0]    w_row       [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_elig;
   logic [NUM_PORTS-1:0] w_gnt;
   logic                w_conflict;

   logic [NUM_BANKS-1:0] w_bank_gnt;
   logic [PORT_W-1:0]   w_bank_win   [NUM_BANKS];
   logic                w_bank_we    [NUM_BANKS];
   logic [BE_W-1:0]     w_bank_be    [NUM_BANKS];
   logic [ROW_W-1:0]    w_bank_row   [NUM_BANKS];
   logic [DATA_W-1:0]   w_bank_wdata [NUM_BANKS];

   logic [PORT_W-1:0]   r_ptr   [NUM_BANKS];
   logic [NUM_PORTS-1:0] r_ready;
   logic [DATA_W-1:0]   r_rdata [NUM_PORTS];
   logic [15:0]         r_cnt;
   logic [DATA_W-1:0]   r_mem   [NUM_BANKS][ROWS];

   // The two byte-offset bits never select anything; words are the unit.
   logic                w_unused_addr;

   // Address decode and eligibility: a port in DONE ignores its request.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_unused_addr = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_word[p]     = mem_addr[p*ADDR_W+2 +: WORD_W];
         w_bank[p]     = BANK_W'(w_word[p] % NUM_BANKS);
         w_row[p]      = ROW_W'((w_word[p] >> LOG_NB) % ROWS);
         w_elig[p]     = mem_req[p] && (r_state[p] != ST_DONE);
         w_unused_addr = w_unused_addr ^ (^mem_addr[p*ADDR_W +: 2]);
      end
   end

   // Per-bank arbitration: scan from port 0 (fixed) or from the bank pointer (RR).
   always_comb begin
      w_gnt = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_bank_gnt[b]   = 1'b0;
         w_bank_win[b]   = '0;
         w_bank_we[b]    = 1'b0;
         w_bank_be[b]    = '0;
         w_bank_row[b]   = '0;
         w_bank_wdata[b] = '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            int idx;
            idx = (ARB_MODE == 1) ? ((int'(r_ptr[b]) + k) % NUM_PORTS) : k;
            if (!w_bank_gnt[b] && w_elig[idx] && (w_bank[idx] == BANK_W'(b))) begin
               w_bank_gnt[b]   = 1'b1;
               w_bank_win[b]   = PORT_W'(idx);
               w_bank_we[b]    = mem_we[idx];
               w_bank_be[b]    = mem_be[idx*BE_W +: BE_W];
               w_bank_row[b]   = w_row[idx];
               w_bank_wdata[b] = mem_wdata[idx*DATA_W +: DATA_W];
               w_gnt[idx]      = 1'b1;
            end
         end
      end
      w_conflict = |(w_elig & ~w_gnt);
   end

   // Per-port next state: grant -> DONE for one cycle, losers wait, drops cancel.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_state_nxt[p] = r_state[p];
         case (r_state[p])
            ST_DONE: w_state_nxt[p] = ST_IDLE;
            default: begin
               if (w_gnt[p])        w_state_nxt[p] = ST_DONE;
               else if (mem_req[p]) w_state_nxt[p] = ST_WAIT;
               else                 w_state_nxt[p] = ST_IDLE;
            end
         endcase
      end
   end

   // Per-port state register.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rst) r_state[p] <= ST_IDLE;
         else     r_state[p] <= w_state_nxt[p];
      end
   end

   // Completion pulse, read data capture, round-robin pointers and conflict counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready <= '0;
         r_cnt   <= '0;
         for (int p = 0; p < NUM_PORTS; p++) r_rdata[p] <= '0;
         for (int b = 0; b < NUM_BANKS; b++) r_ptr[b]   <= '0;
      end else begin
         r_ready <= w_gnt;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt[p]) r_rdata[p] <= r_mem[w_bank[p]][w_row[p]];
         end
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_bank_gnt[b]) r_ptr[b] <= PORT_W'((int'(w_bank_win[b]) + 1) % NUM_PORTS);
         end
         if (w_conflict && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
      end
   end

   // Bank storage with byte-lane writes; a write granted on a reset edge is dropped.
   // NOTE: the memory array has no reset branch; contents survive reset and map onto block RAM.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (!rst && w_bank_gnt[b] && w_bank_we[b]) begin
            for (int i = 0; i < BE_W; i++) begin
               if (w_bank_be[b][i])
                  r_mem[b][w_bank_row[b]][8*i +: 8] <= w_bank_wdata[b][8*i +: 8];
            end
         end
      end
   end

   // Output mapping.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) mem_rdata[p*DATA_W +: DATA_W] = r_rdata[p];
      mem_ready    = r_ready;
      conflict_cnt = r_cnt;
   end

endmodule

// File: tb/tb_banked_mem_arbiter.sv
// Directed bench: a two-port fixed-priority instance for data-path, conflict,
// reset and mixed-traffic checks, and a four-port round-robin instance for
// rotation checks.
module tb_banked_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Two-port, fixed-priority instance.
   logic        p_req   [2];
   logic        p_we    [2];
   logic [3:0]  p_be    [2];
   logic [31:0] p_addr  [2];
   logic [31:0] p_wdata [2];
   logic [1:0]  m0_req, m0_we;
   logic [7:0]  m0_be;
   logic [63:0] m0_addr, m0_wdata, m0_rdata;
   logic [1:0]  m0_ready;
   logic [15:0] m0_cnt;

   assign m0_req   = {p_req[1], p_req[0]};
   assign m0_we    = {p_we[1], p_we[0]};
   assign m0_be    = {p_be[1], p_be[0]};
   assign m0_addr  = {p_addr[1], p_addr[0]};
   assign m0_wdata = {p_wdata[1], p_wdata[0]};

   banked_mem_arbiter #(.NUM_PORTS(2), .NUM_BANKS(4), .ARB_MODE(0)) dut0 (
      .clk(clk), .rst(rst),
      .mem_req(m0_req), .mem_we(m0_we), .mem_be(m0_be),
      .mem_addr(m0_addr), .mem_wdata(m0_wdata),
      .mem_rdata(m0_rdata), .mem_ready(m0_ready), .conflict_cnt(m0_cnt)
   );

   // Four-port, round-robin instance; every port targets bank 0 with reads.
   logic [3:0]   h_req   = '0;
   logic [3:0]   h_we    = '0;
   logic [15:0]  h_be    = '1;
   logic [127:0] h_addr  = '0;
   logic [127:0] h_wdata = '0;
   logic [127:0] m1_rdata;
   logic [3:0]   m1_ready;
   logic [15:0]  m1_cnt;

   banked_mem_arbiter #(.NUM_PORTS(4), .NUM_BANKS(4), .ARB_MODE(1)) dut1 (
      .clk(clk), .rst(rst),
      .mem_req(h_req), .mem_we(h_we), .mem_be(h_be),
      .mem_addr(h_addr), .mem_wdata(h_wdata),
      .mem_rdata(m1_rdata), .mem_ready(m1_ready), .conflict_cnt(m1_cnt)
   );

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic chk, input logic [31:0] exp);
      vec_t v;
      v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp = exp;
      vt.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One transaction on dut0 port p; lat = cycles to ready, or -1 on timeout.
   task automatic do_txn(input int p, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat);
      @(negedge clk);
      p_we[p] = we; p_be[p] = be; p_addr[p] = addr; p_wdata[p] = wdata;
      p_req[p] = 1'b1;
      lat   = -1;
      rdata = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (m0_ready[p]) begin
            lat   = c;
            rdata = m0_rdata[p*32 +: 32];
            break;
         end
      end
      p_req[p] = 1'b0;
   endtask

   // Mixed reads/writes with random byte enables on a private 16-word region.
   task automatic port_traffic(input int p);
      logic [31:0] mdl [16];
      bit          vld [16];
      logic [31:0] base, rd, wd;
      logic [3:0]  be;
      logic        we;
      int          idx, lat;
      base = (p == 0) ? 32'h6000 : 32'h7000;
      for (int i = 0; i < 16; i++) vld[i] = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         do_txn(p, 1'b1, 4'hF, base + 32'(4*i), wd, rd, lat);
         check("init_ready", 32'(lat > 0), 32'd1);
         mdl[i] = wd; vld[i] = 1'b1;
      end
      for (int n = 0; n < 200; n++) begin
         idx = $urandom_range(0, 15);
         we  = 1'($urandom_range(0, 1));
         be  = 4'($urandom_range(0, 15));
         wd  = $urandom;
         do_txn(p, we, be, base + 32'(4*idx), wd, rd, lat);
         check("rand_ready", 32'(lat > 0), 32'd1);
         if (vld[idx]) check("rand_rdata", rd, mdl[idx]);
         if (we) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) mdl[idx][8*i +: 8] = wd[8*i +: 8];
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          lat;

      for (int p = 0; p < 2; p++) begin
         p_req[p] = 1'b0; p_we[p] = 1'b0; p_be[p] = 4'h0;
         p_addr[p] = '0; p_wdata[p] = '0;
      end

      // Stimulus table: port 0 alone, one transaction per row.
      for (int i = 0; i < 32; i++) add(1'b1, 4'hF, 32'(4*i), 32'h11110000 + 32'(i), 1'b0, '0);
      for (int i = 0; i < 32; i++) add(1'b0, 4'h0, 32'(4*i), '0, 1'b1, 32'h11110000 + 32'(i));
      add(1'b1, 4'hF, 32'h100,  32'h12345678, 1'b0, '0);
      add(1'b1, 4'h5, 32'h100,  32'hFFFFFFFF, 1'b1, 32'h12345678);
      add(1'b0, 4'h0, 32'h100,  '0,           1'b1, 32'h12FF56FF);
      add(1'b1, 4'h0, 32'h100,  32'h00000000, 1'b1, 32'h12FF56FF);
      add(1'b0, 4'h0, 32'h103,  '0,           1'b1, 32'h12FF56FF);
      add(1'b0, 4'h0, 32'h8100, '0,           1'b1, 32'h12FF56FF);

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_ready0", 32'(m0_ready), 32'd0);
      check("rst_rdata0", m0_rdata[63:32] | m0_rdata[31:0], 32'd0);
      check("rst_cnt0",   32'(m0_cnt), 32'd0);
      check("rst_ready1", 32'(m1_ready), 32'd0);
      check("rst_cnt1",   32'(m1_cnt), 32'd0);
      rst = 1'b0;

      // Round-robin rotation with all four ports hammering bank 0.
      @(negedge clk);
      h_req = 4'hF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("rr_grant", 32'(m1_ready), 32'd1 << (k % 4));
      end
      check("rr_cnt", 32'(m1_cnt), 32'd8);
      h_req = '0;

      // Table-driven single-port sequence.
      foreach (vt[i]) begin
         do_txn(0, vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, rd, lat);
         check("tbl_lat", 32'(lat), 32'd1);
         if (vt[i].chk) check("tbl_rdata", rd, vt[i].exp);
      end
      check("tbl_cnt", 32'(m0_cnt), 32'd0);

      // Same-address simultaneous writes under fixed priority.
      @(negedge clk);
      p_we[0] = 1'b1; p_be[0] = 4'hF; p_addr[0] = 32'h3000; p_wdata[0] = 32'hAAAAAAAA;
      p_we[1] = 1'b1; p_be[1] = 4'hF; p_addr[1] = 32'h3000; p_wdata[1] = 32'hBBBBBBBB;
      p_req[0] = 1'b1; p_req[1] = 1'b1;
      @(negedge clk);
      check("conf_ready_a", 32'(m0_ready), 32'b01);
      check("conf_cnt_a",   32'(m0_cnt), 32'd1);
      p_req[0] = 1'b0;
      @(negedge clk);
      check("conf_ready_b", 32'(m0_ready), 32'b10);
      check("conf_prewrite", m0_rdata[63:32], 32'hAAAAAAAA);
      p_req[1] = 1'b0;
      @(negedge clk);
      check("conf_pulse", 32'(m0_ready), 32'b00);
      check("conf_cnt_b", 32'(m0_cnt), 32'd1);
      do_txn(0, 1'b0, 4'h0, 32'h3000, '0, rd, lat);
      check("conf_readback", rd, 32'hBBBBBBBB);

      // Different banks are served in the same cycle.
      @(negedge clk);
      p_we[0] = 1'b0; p_addr[0] = 32'h4000;
      p_we[1] = 1'b0; p_addr[1] = 32'h4004;
      p_req[0] = 1'b1; p_req[1] = 1'b1;
      @(negedge clk);
      check("par_ready", 32'(m0_ready), 32'b11);
      check("par_cnt",   32'(m0_cnt), 32'd1);
      p_req[0] = 1'b0; p_req[1] = 1'b0;

      // Reset while port 1 waits with a write pending.
      @(negedge clk);
      p_we[0] = 1'b0; p_addr[0] = 32'h3000;
      p_we[1] = 1'b1; p_be[1] = 4'hF; p_addr[1] = 32'h3000; p_wdata[1] = 32'hDEADBEEF;
      p_req[0] = 1'b1; p_req[1] = 1'b1;
      @(negedge clk);
      check("rw_ready_pre", 32'(m0_ready), 32'b01);
      check("rw_cnt_pre",   32'(m0_cnt), 32'd2);
      rst = 1'b1; p_req[0] = 1'b0;
      @(negedge clk);
      check("rw_ready_rst", 32'(m0_ready), 32'b00);
      check("rw_cnt_rst",   32'(m0_cnt), 32'd0);
      check("rw_rdata_rst", m0_rdata[63:32] | m0_rdata[31:0], 32'd0);
      rst = 1'b0; p_req[1] = 1'b0;
      @(negedge clk);
      check("rw_ready_post", 32'(m0_ready), 32'b00);
      do_txn(0, 1'b0, 4'h0, 32'h3000, '0, rd, lat);
      check("rw_unchanged", rd, 32'hBBBBBBBB);

      // Mixed traffic on disjoint regions from both ports at once.
      fork
         port_traffic(0);
         port_traffic(1);
      join

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
